// File: rtl/uart_transmitter_pkg.sv
// Shared constants for the UART transmitter: FSM encoding, parity
// selection and TX line levels.
package uart_transmitter_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // parity_type encoding
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // TX line levels
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Parity bit for a byte-sized or smaller word is built at the top
  // level with a reduction XOR; this helper folds in the odd/even select.
  function automatic logic parity_bit(input logic xor_red, input logic ptype);
    return xor_red ^ (ptype == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_transmitter_serializer.sv
// Data-bit shifter: holds the word being sent (LSB first) and counts the
// data bits so the FSM knows when the last one is on the line.
module uart_tx_serializer
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift_en,
  input  logic                  i_count_en,
  output logic                  o_bit,
  output logic                  o_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  // Shift register: load on accept, then move the next bit into [0]
  // every time the FSM consumes one.
  always_ff @(posedge clk) begin
    if (reset)           r_shift <= '0;
    else if (i_load)     r_shift <= i_data;
    else if (i_shift_en) r_shift <= r_shift >> 1;
  end

  // Bit counter: runs only while in DATA, parks at LAST, cleared otherwise.
  always_ff @(posedge clk) begin
    if (reset || i_load || !i_count_en) r_cnt <= '0;
    else if (r_cnt != LAST)             r_cnt <= r_cnt + 1'b1;
  end

  assign o_bit  = r_shift[0];
  assign o_done = i_count_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART TX framer: start bit, DATA_WIDTH data bits LSB first, optional
// parity, stop bit. One clk = one bit period. Back-to-back frames are
// accepted in STOP so the line has no idle gap between them.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  parallel_data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  serial_data_out,
  output logic                  busy
);

  logic [2:0] r_state;
  logic       r_out;
  logic       r_busy;
  logic       r_par_en;
  logic       r_par_bit;

  logic w_accept;
  logic w_shift_en;
  logic w_count_en;
  logic w_ser_bit;
  logic w_done;

  assign w_accept   = parallel_data_valid && (r_state == ST_IDLE || r_state == ST_STOP);
  // bit 0 leaves the shifter on the START edge, later bits on DATA edges
  assign w_shift_en = (r_state == ST_START) || (r_state == ST_DATA && !w_done);
  assign w_count_en = (r_state == ST_DATA);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_data     (parallel_data),
    .i_shift_en (w_shift_en),
    .i_count_en (w_count_en),
    .o_bit      (w_ser_bit),
    .o_done     (w_done)
  );

  // Frame options are captured at accept so mid-frame input changes are inert.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_par_en  <= parity_enable;
      r_par_bit <= parity_bit(^parallel_data, parity_type);
    end
  end

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out   <= IDLE_LEVEL;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_STOP: begin
          if (w_accept) begin
            r_state <= ST_START;
            r_out   <= START_BIT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_out   <= IDLE_LEVEL;
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          r_state <= ST_DATA;
          r_out   <= w_ser_bit;
        end
        ST_DATA: begin
          if (!w_done) begin
            r_out <= w_ser_bit;
          end else if (r_par_en) begin
            r_state <= ST_PARITY;
            r_out   <= r_par_bit;
          end else begin
            r_state <= ST_STOP;
            r_out   <= STOP_BIT;
          end
        end
        ST_PARITY: begin
          r_state <= ST_STOP;
          r_out   <= STOP_BIT;
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= IDLE_LEVEL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_data_out = r_out;
  assign busy            = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: expected line sequences are written
// out by hand as strings, first character = first bit on the line.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       parallel_data_valid;
  logic [7:0] parallel_data;
  logic       parity_enable;
  logic       parity_type;
  logic       serial_data_out;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;

  uart_transmitter #(.DATA_WIDTH(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .parallel_data_valid (parallel_data_valid),
    .parallel_data       (parallel_data),
    .parity_enable       (parity_enable),
    .parity_type         (parity_type),
    .serial_data_out     (serial_data_out),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller sets inputs at a negedge with valid=1. Samples one line bit per
  // negedge; busy must be high for the whole sequence, then idle after.
  // mode 0: single frame, inputs scrambled after accept
  // mode 1: back-to-back, valid held, second word 0xF0
  // mode 2: one-cycle valid pulse with 0x55 during DATA
  task automatic run_seq(input string tag, input string s, input int mode);
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) begin
      chk($sformatf("%s.line[%0d]", tag, i), 32'(serial_data_out), (s[i] == "1") ? 32'd1 : 32'd0);
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
      if (mode == 0 && i == 0) begin
        parallel_data_valid = 1'b0;
        parallel_data       = ~parallel_data;
        parity_enable       = ~parity_enable;
        parity_type         = ~parity_type;
      end
      if (mode == 1 && i == 0)  parallel_data = 8'hF0;
      if (mode == 1 && i == 10) parallel_data_valid = 1'b0;
      if (mode == 2 && i == 0)  parallel_data_valid = 1'b0;
      if (mode == 2 && i == 4) begin
        parallel_data_valid = 1'b1;
        parallel_data       = 8'h55;
      end
      if (mode == 2 && i == 5)  parallel_data_valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, ".idle_line"}, 32'(serial_data_out), 32'd1);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    parallel_data_valid = 1'b1;
    parallel_data       = d;
    parity_enable       = pe;
    parity_type         = pt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    parallel_data_valid = 1'b0;
    parallel_data = 8'h00;
    parity_enable = 1'b0;
    parity_type   = 1'b0;

    // reset held 3 cycles, then idle with valid low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst.line[%0d]", i), 32'(serial_data_out), 32'd1);
      chk($sformatf("rst.busy[%0d]", i), 32'(busy), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle.line[%0d]", i), 32'(serial_data_out), 32'd1);
      chk($sformatf("idle.busy[%0d]", i), 32'(busy), 32'd0);
    end

    start(8'hA5, 1'b0, 1'b0);
    run_seq("a5_np", "0101001011", 0);

    @(negedge clk);
    start(8'hA5, 1'b1, 1'b0);
    run_seq("a5_even", "01010010101", 0);

    @(negedge clk);
    start(8'h01, 1'b1, 1'b1);
    run_seq("01_odd", "01000000001", 0);

    @(negedge clk);
    start(8'h03, 1'b1, 1'b1);
    run_seq("03_odd", "01100000011", 0);

    @(negedge clk);
    start(8'h0F, 1'b0, 1'b0);
    run_seq("b2b", "01111000010000011111", 1);

    @(negedge clk);
    start(8'h00, 1'b0, 1'b0);
    run_seq("ign", "0000000001", 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ign.after_line[%0d]", i), 32'(serial_data_out), 32'd1);
      chk($sformatf("ign.after_busy[%0d]", i), 32'(busy), 32'd0);
    end

    // reset while data bit 3 of 0xFF is on the line
    start(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    parallel_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rmid.line[%0d]", i), 32'(serial_data_out), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rmid.busy[%0d]", i), 32'(busy), 32'd1);
      if (i == 4) begin
        reset = 1'b1;
        parallel_data_valid = 1'b1;
      end
      @(negedge clk);
    end
    chk("rmid.line_after", 32'(serial_data_out), 32'd1);
    chk("rmid.busy_after", 32'(busy), 32'd0);
    chk("rmid.state_after", 32'(dut.r_state), 32'd0);
    reset = 1'b0;
    start(8'h3C, 1'b0, 1'b0);
    run_seq("post_rst", "0001111001", 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
